// File: rtl/muldiv_pkg.sv
// Shared definitions for the arbitrated iterative multiply/divide unit.
package muldiv_pkg;
    localparam int DEFAULT_WIDTH = 8;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/muldiv_iter_engine.sv
// One-bit-per-cycle shift-add multiplier / restoring divider sharing a {hi, lo} register pair.
// The first iteration is performed on the start edge directly from the input operands.
module muldiv_iter_engine
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] result,
    output logic               dz
);
    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_b;
    logic             r_op;
    logic             r_busy;
    logic             r_done;
    logic [CW-1:0]    r_cnt;

    logic             w_go;
    logic [WIDTH-1:0] w_hi_in;
    logic [WIDTH-1:0] w_lo_in;
    logic [WIDTH-1:0] w_b_in;
    logic             w_op_in;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_add;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_hi_next;
    logic [WIDTH-1:0] w_lo_next;

    always_comb begin
        dz      = start && (op == OP_DIV) && (b == '0);
        w_go    = (start && !dz) || r_busy;
        w_hi_in = start ? '0 : r_hi;
        w_lo_in = start ? a  : r_lo;
        w_b_in  = start ? b  : r_b;
        w_op_in = start ? op : r_op;

        w_sum   = {1'b0, w_hi_in} + {1'b0, w_b_in};
        w_add   = w_lo_in[0] ? w_sum : {1'b0, w_hi_in};
        // Remainder stays below the divisor, so the shifted partial fits in WIDTH+1 bits.
        w_shift = {w_hi_in, w_lo_in[WIDTH-1]};
        w_diff  = w_shift - {1'b0, w_b_in};

        w_hi_next = w_shift[WIDTH-1:0];
        w_lo_next = {w_lo_in[WIDTH-2:0], 1'b0};
        if (w_op_in == OP_MUL) begin
            w_hi_next = w_add[WIDTH:1];
            w_lo_next = {w_add[0], w_lo_in[WIDTH-1:1]};
        end else if (!w_diff[WIDTH]) begin
            w_hi_next = w_diff[WIDTH-1:0];
            w_lo_next = {w_lo_in[WIDTH-2:0], 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hi   <= '0;
            r_lo   <= '0;
            r_b    <= '0;
            r_op   <= OP_MUL;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_cnt  <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_go) begin
                r_hi <= w_hi_next;
                r_lo <= w_lo_next;
                if (start) begin
                    r_b    <= b;
                    r_op   <= op;
                    r_cnt  <= CW'(WIDTH - 1);
                    r_busy <= 1'b1;
                end else begin
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        r_busy <= 1'b0;
                        r_done <= 1'b1;
                    end
                end
            end
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign result = {r_hi, r_lo};
endmodule

// File: rtl/muldiv_arbiter.sv
// Two-requester round-robin front end for the iterative engine, with a held response.
module muldiv_arbiter
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic               req0_op,
    input  logic [WIDTH-1:0]   req0_a,
    input  logic [WIDTH-1:0]   req0_b,
    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic               req1_op,
    input  logic [WIDTH-1:0]   req1_a,
    input  logic [WIDTH-1:0]   req1_b,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic               rsp_id,
    output logic [2*WIDTH-1:0] rsp_result,
    output logic               rsp_dz
);
    state_t             r_state;
    state_t             w_state_next;
    logic               r_ptr;
    logic               r_rsp_id;
    logic [2*WIDTH-1:0] r_rsp_result;
    logic               r_rsp_dz;

    logic               w_gnt_valid;
    logic               w_gnt_id;
    logic               w_sel_op;
    logic [WIDTH-1:0]   w_sel_a;
    logic [WIDTH-1:0]   w_sel_b;
    logic               w_eng_busy;
    logic               w_eng_done;
    logic               w_eng_dz;
    logic [2*WIDTH-1:0] w_eng_result;

    // r_ptr names the requester favoured when both are pending.
    always_comb begin
        w_gnt_valid  = (r_state == IDLE) && (req0_valid || req1_valid);
        w_gnt_id     = (req0_valid && req1_valid) ? r_ptr : req1_valid;
        req0_ready   = w_gnt_valid && !w_gnt_id;
        req1_ready   = w_gnt_valid && w_gnt_id;
        w_sel_op     = w_gnt_id ? req1_op : req0_op;
        w_sel_a      = w_gnt_id ? req1_a  : req0_a;
        w_sel_b      = w_gnt_id ? req1_b  : req0_b;

        w_state_next = r_state;
        unique case (r_state)
            IDLE: if (w_gnt_valid) w_state_next = w_eng_dz ? DONE : RUN;
            RUN:  if (w_eng_done && !w_eng_busy) w_state_next = DONE;
            DONE: if (rsp_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr        <= 1'b0;
            r_rsp_id     <= 1'b0;
            r_rsp_result <= '0;
            r_rsp_dz     <= 1'b0;
        end else if (w_gnt_valid) begin
            r_ptr    <= ~w_gnt_id;
            r_rsp_id <= w_gnt_id;
            r_rsp_dz <= w_eng_dz;
            if (w_eng_dz) begin
                r_rsp_result <= {w_sel_a, {WIDTH{1'b1}}};
            end
        end else if (r_state == RUN && w_eng_done) begin
            r_rsp_result <= w_eng_result;
            r_rsp_dz     <= 1'b0;
        end
    end

    muldiv_iter_engine #(.WIDTH(WIDTH)) u_engine (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (w_gnt_valid),
        .op     (w_sel_op),
        .a      (w_sel_a),
        .b      (w_sel_b),
        .busy   (w_eng_busy),
        .done   (w_eng_done),
        .result (w_eng_result),
        .dz     (w_eng_dz)
    );

    assign rsp_valid  = (r_state == DONE);
    assign rsp_id     = r_rsp_id;
    assign rsp_result = r_rsp_result;
    assign rsp_dz     = r_rsp_dz;
endmodule

// File: tb/tb_muldiv_arbiter.sv
// Directed bench for muldiv_arbiter: scoreboard of expected responses, round-robin model, reset abort.
module tb_muldiv_arbiter;
    localparam int W = 8;

    logic            clk;
    logic            rst_n;
    logic            req0_valid, req0_ready, req0_op;
    logic [W-1:0]    req0_a, req0_b;
    logic            req1_valid, req1_ready, req1_op;
    logic [W-1:0]    req1_a, req1_b;
    logic            rsp_valid, rsp_ready, rsp_id, rsp_dz;
    logic [2*W-1:0]  rsp_result;

    typedef struct {
        logic           id;
        logic [2*W-1:0] res;
        logic           dz;
        int             lat;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    logic last_gnt = 1'b1;

    muldiv_arbiter #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_dz     (rsp_dz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2*W-1:0] model(input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] r;
        if (op == 1'b0) r = (2*W)'(a) * (2*W)'(b);
        else if (b == '0) r = {a, {W{1'b1}}};
        else r = {W'(a % b), W'(a / b)};
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic finish_tb();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    endtask

    task automatic set_req(input logic id, input logic v, input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
        if (!id) begin
            req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
        end else begin
            req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
        end
    endtask

    // Waits for a grant, checks it, records the expected response, returns just after the accept edge.
    task automatic expect_grant(input logic exp_id, input logic keep);
        int   k;
        logic g;
        exp_t e;
        for (k = 0; k < 50; k++) begin
            #1;
            if (req0_ready || req1_ready) break;
            @(negedge clk);
        end
        if (k == 50) begin
            check("grant_timeout", 32'd0, 32'd1);
            finish_tb();
        end
        check("one_ready", 32'(req0_ready & req1_ready), 32'd0);
        g = req1_ready;
        check("grant_id", 32'(g), 32'(exp_id));
        e.id  = g;
        e.res = g ? model(req1_op, req1_a, req1_b) : model(req0_op, req0_a, req0_b);
        e.dz  = g ? (req1_op && req1_b == '0) : (req0_op && req0_b == '0);
        e.lat = e.dz ? 1 : W + 1;
        sb.push_back(e);
        @(posedge clk);
        last_gnt = g;
        if (!keep) begin
            #1;
            if (g) req1_valid = 1'b0;
            else   req0_valid = 1'b0;
        end
    endtask

    // Counts cycles from the accept edge to rsp_valid and compares against the scoreboard head.
    task automatic expect_rsp();
        int   lat;
        exp_t e;
        for (lat = 1; lat <= 40; lat++) begin
            @(negedge clk);
            if (rsp_valid) break;
        end
        if (lat > 40) begin
            check("rsp_timeout", 32'd0, 32'd1);
            finish_tb();
        end
        if (sb.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check("latency", 32'(lat), 32'(e.lat));
            check("rsp_id", 32'(rsp_id), 32'(e.id));
            check("rsp_result", 32'(rsp_result), 32'(e.res));
            check("rsp_dz", 32'(rsp_dz), 32'(e.dz));
            $display("[TB] rsp id=%0d result=0x%04h dz=%0d latency=%0d", rsp_id, rsp_result, rsp_dz, lat);
        end
    endtask

    task automatic release_rsp();
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
        check("rsp_drop", 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        int seen;
        rst_n = 1'b0;
        rsp_ready = 1'b0;
        set_req(1'b0, 1'b0, 1'b0, '0, '0);
        set_req(1'b1, 1'b0, 1'b0, '0, '0);
        #1;
        check("rst_valid", 32'(rsp_valid), 32'd0);
        check("rst_id", 32'(rsp_id), 32'd0);
        check("rst_result", 32'(rsp_result), 32'd0);
        check("rst_dz", 32'(rsp_dz), 32'd0);
        check("rst_ready", 32'({req0_ready, req1_ready}), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic operations, one requester at a time
        set_req(1'b0, 1'b1, 1'b0, 8'd5, 8'd5);
        expect_grant(1'b0, 1'b0); expect_rsp(); release_rsp();
        set_req(1'b1, 1'b1, 1'b1, 8'd15, 8'd3);
        expect_grant(1'b1, 1'b0); expect_rsp(); release_rsp();
        set_req(1'b1, 1'b1, 1'b1, 8'd200, 8'd7);
        expect_grant(1'b1, 1'b0); expect_rsp(); release_rsp();
        set_req(1'b0, 1'b1, 1'b1, 8'd200, 8'd0);
        expect_grant(1'b0, 1'b0); expect_rsp(); release_rsp();

        // Response held off for 5 cycles while another request waits
        set_req(1'b0, 1'b1, 1'b0, 8'd13, 8'd17);
        expect_grant(1'b0, 1'b0); expect_rsp();
        set_req(1'b1, 1'b1, 1'b1, 8'd100, 8'd9);
        for (int i = 0; i < 5; i++) begin
            #1;
            check("hold_valid", 32'(rsp_valid), 32'd1);
            check("hold_result", 32'(rsp_result), 32'(model(1'b0, 8'd13, 8'd17)));
            check("hold_id_dz", 32'({rsp_id, rsp_dz}), 32'd0);
            check("hold_ready", 32'({req0_ready, req1_ready}), 32'd0);
            @(negedge clk);
        end
        release_rsp();
        expect_grant(1'b1, 1'b0); expect_rsp(); release_rsp();

        // Both requesters pending continuously with the consumer always ready
        rsp_ready = 1'b1;
        set_req(1'b0, 1'b1, 1'b0, 8'd255, 8'd255);
        set_req(1'b1, 1'b1, 1'b0, 8'd12, 8'd34);
        for (int i = 0; i < 4; i++) begin
            expect_grant(~last_gnt, 1'b1);
            expect_rsp();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);

        // Reset in the middle of RUN aborts the operation
        set_req(1'b0, 1'b1, 1'b0, 8'd13, 8'd11);
        expect_grant(1'b0, 1'b0);
        sb.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_valid", 32'(rsp_valid), 32'd0);
        check("abort_id", 32'(rsp_id), 32'd0);
        check("abort_result", 32'(rsp_result), 32'd0);
        check("abort_dz", 32'(rsp_dz), 32'd0);
        check("abort_ready", 32'({req0_ready, req1_ready}), 32'd0);
        last_gnt = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        check("no_rsp_after_abort", 32'(seen), 32'd0);

        set_req(1'b0, 1'b1, 1'b0, 8'd9, 8'd9);
        set_req(1'b1, 1'b1, 1'b1, 8'd50, 8'd6);
        expect_grant(1'b0, 1'b0); expect_rsp(); release_rsp();
        expect_grant(1'b1, 1'b0); expect_rsp(); release_rsp();

        finish_tb();
    end
endmodule

// File: doc/muldiv_arbiter.md
MULDIV_ARBITER -- requirements
Module: muldiv_arbiter

Interface
REQ-001 SHALL have parameter: WIDTH, 8, operand width in bits (min 2).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have ports: reqN_valid  input  1  requester N (N=0,1) has an operation pending.
REQ-005 SHALL have ports: reqN_ready  output  1  requester N operation accepted this cycle.
REQ-006 SHALL have ports: reqN_op  input  1  requester N opcode; 0 = multiply, 1 = divide.
REQ-007 SHALL have ports: reqN_a, reqN_b  input  WIDTH  requester N operands, unsigned; b is the divisor.
REQ-008 SHALL have port: rsp_valid  output  1  result available.
REQ-009 SHALL have port: rsp_ready  input  1  consumer takes result.
REQ-010 SHALL have port: rsp_id  output  1  requester that owns the result.
REQ-011 SHALL have port: rsp_result  output  2*WIDTH  multiply: product; divide: {remainder, quotient}.
REQ-012 SHALL have port: rsp_dz  output  1  divide-by-zero flag.

Function
REQ-013 SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-014 IDLE arbitration SHALL grant the only valid requester; when both are valid, it SHALL grant the requester that was not granted last (round-robin). The pointer after reset SHALL favour req0.
REQ-015 reqN_ready SHALL be asserted combinationally only in IDLE, for the granted requester only. At most one ready SHALL be high per cycle.
REQ-016 On accept (valid & ready), the block SHALL latch a, b, op and id, then go to RUN. For a divide with b == 0 it SHALL go directly to DONE instead.
REQ-017 RUN SHALL take exactly WIDTH cycles. Multiply SHALL use shift-add, one bit per cycle. Divide SHALL use restoring division, one quotient bit per cycle.
REQ-018 In the normal case, rsp_valid SHALL rise exactly WIDTH+1 cycles after the accept edge. For divide-by-zero it SHALL rise 1 cycle after the accept edge.
REQ-019 Multiply results SHALL be exact over 2*WIDTH bits with no truncation: 255*255 = 65025.
REQ-020 Divide results: quotient = a/b and remainder = a%b, with the remainder in the upper WIDTH bits.
REQ-021 Divide-by-zero SHALL return quotient all ones, remainder = a, and rsp_dz = 1. rsp_dz SHALL be 0 for every other result.
REQ-022 In DONE, rsp_valid, rsp_id, rsp_result and rsp_dz SHALL hold stable until rsp_ready is sampled high.
REQ-023 When DONE sees rsp_ready high, the FSM SHALL go to IDLE. New requests SHALL be accepted no earlier than the following cycle; there is no overlap of operations.
REQ-024 Requests arriving while not in IDLE SHALL see ready = 0 and SHALL NOT be lost. Requesters hold valid until they are accepted.
REQ-025 The round-robin pointer SHALL update on accept.

Reset
REQ-026 When rst_n is low, the block SHALL immediately set: state = IDLE, rsp_valid = 0, rsp_id = 0, rsp_result = 0, rsp_dz = 0, pointer = req0. Iteration counter and operand registers SHALL be cleared.
REQ-027 A reset asserted during RUN or DONE SHALL abort the operation with no result. The first grant after release SHALL follow the reset pointer.

Structure
REQ-028 A shared package (muldiv_pkg) SHALL hold the FSM state encoding, opcode constants (OP_MUL = 0, OP_DIV = 1) and the default WIDTH.
REQ-029 The iterative datapath SHALL be sub-module muldiv_iter_engine, with inputs start, op, a, b and outputs busy, done, result, dz. The muldiv_arbiter top SHALL own arbitration, the FSM and the response handshake.

Verification
REQ-030 req0 mul a=5, b=5 -> rsp_result = 25, rsp_id = 0, rsp_dz = 0, rsp_valid exactly 9 cycles after accept.
REQ-031 req1 div a=15, b=3 -> quotient 5, remainder 0, rsp_id = 1. Also a=200, b=7 -> quotient 28, remainder 4.
REQ-032 req0 div a=200, b=0 -> rsp_dz = 1, quotient 0xFF, remainder 200, rsp_valid 1 cycle after accept.
REQ-033 Both requesters valid continuously with rsp_ready = 1 -> grants alternate 0,1,0,1. Also 255*255 -> 65025.
REQ-034 rsp_ready held 0 for 5 cycles in DONE -> outputs stable, both ready = 0. Result is released on the first cycle rsp_ready = 1.
REQ-035 rst_n pulsed low mid-RUN -> all outputs 0 immediately, no response issued. The next request completes correctly.
